// File: rtl/sc_pkg.sv
// Shared constants and FSM state type for the stochastic-computing accumulator.
//   DIM_IN  : input neurons per output neuron
//   DIM_OUT : output neurons handled in parallel
//   INWD    : bitstream length exponent (LEN = 2**INWD beats)
//   ACCWD   : accumulator width, wide enough for DIM_IN * LEN
package sc_pkg;

  localparam int unsigned DIM_IN  = 110;
  localparam int unsigned DIM_OUT = 8;
  localparam int unsigned INWD    = 8;
  localparam int unsigned ACCWD   = INWD + $clog2(DIM_IN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sc_popcnt.sv
// Combinational population count.
//   bits    : N input bits
//   count_c : number of ones in bits (combinational)
module sc_popcnt #(
  parameter  int unsigned N  = sc_pkg::DIM_IN,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count_c
);

  // Ripple sum of single bits; synthesis rebalances into an adder tree.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      count_c = count_c + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/sc_accum.sv
// Stochastic-computing dot-product accumulator.
// Counts, per output neuron, the ones in the AND of each weight bitstream with
// its activation bitstream over LEN = 2**INWD valid beats.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a new stream (honoured only in IDLE)
//   in_valid   : cmp_out / act_bit carry a valid beat
//   cmp_out    : weight bitstream bits [DIM_OUT][DIM_IN]
//   act_bit    : activation bitstream bits [DIM_IN]
//   rng_en     : advance enable for upstream RNGs (RUN and in_valid)
//   busy       : high in RUN or DONE
//   out_valid  : acc_out is final (DONE)
//   out_ready  : consumer takes acc_out; DONE returns to IDLE
//   acc_out    : per-neuron ones count [DIM_OUT][ACCWD]
module sc_accum #(
  parameter  int unsigned DIM_IN  = sc_pkg::DIM_IN,
  parameter  int unsigned DIM_OUT = sc_pkg::DIM_OUT,
  parameter  int unsigned INWD    = sc_pkg::INWD,
  localparam int unsigned ACCWD   = INWD + $clog2(DIM_IN + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [DIM_OUT-1:0][DIM_IN-1:0]  cmp_out,
  input  logic [DIM_IN-1:0]               act_bit,
  output logic                            rng_en,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIM_OUT-1:0][ACCWD-1:0]   acc_out
);

  import sc_pkg::*;

  localparam int unsigned PCWD = $clog2(DIM_IN + 1);
  localparam int unsigned CNTW = INWD + 1;
  localparam int unsigned LEN  = 1 << INWD;

  state_t                          state_q, state_d;
  logic [DIM_OUT-1:0][ACCWD-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]                 cnt_q, cnt_d;
  logic                            busy_q, busy_d;
  logic                            valid_q, valid_d;
  logic [DIM_OUT-1:0][PCWD-1:0]    pc_c;

  // Per-neuron ones count of the product bitstream for this beat.
  for (genvar j = 0; j < int'(DIM_OUT); j++) begin : g_pc
    sc_popcnt #(.N(DIM_IN)) u_popcnt (
      .bits    (cmp_out[j] & act_bit),
      .count_c (pc_c[j])
    );
  end

  // Next-state, accumulate and output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          for (int j = 0; j < int'(DIM_OUT); j++) begin
            acc_d[j] = acc_q[j] + ACCWD'(pc_c[j]);
          end
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(LEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // All state in one register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // RNG advance follows accepted beats directly so upstream stays in lockstep.
  assign rng_en    = (state_q == RUN) && in_valid;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_sc_accum.sv
// Self-checking bench for sc_accum against a beat-level counting model.
module tb_sc_accum;

  localparam int unsigned NI  = sc_pkg::DIM_IN;
  localparam int unsigned NO  = sc_pkg::DIM_OUT;
  localparam int unsigned LEN = 1 << sc_pkg::INWD;
  localparam int unsigned AW  = sc_pkg::INWD + $clog2(NI + 1);

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic                      in_valid;
  logic [NO-1:0][NI-1:0]     cmp_out;
  logic [NI-1:0]             act_bit;
  logic                      rng_en;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [NO-1:0][AW-1:0]     acc_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int m_state;
  int m_beats;
  int exp_acc [NO];

  sc_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .cmp_out   (cmp_out),
    .act_bit   (act_bit),
    .rng_en    (rng_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < int'(NO); j++) exp_acc[j] = 0;
    m_beats = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_state == M_DONE));
    check("busy", 64'(busy), 64'(m_state != M_IDLE));
    for (int j = 0; j < int'(NO); j++) begin
      check("acc_out", 64'(acc_out[j]), 64'(exp_acc[j]));
    end
  endtask

  // One clock cycle: drive, check rng_en, advance the model, clock, check outputs.
  task automatic cyc(input bit st, input bit v, input bit rdy,
                     input logic [NO-1:0][NI-1:0] c, input logic [NI-1:0] a);
    start     = st;
    in_valid  = v;
    out_ready = rdy;
    cmp_out   = c;
    act_bit   = a;
    #1;
    check("rng_en", 64'(rng_en), 64'(m_state == M_RUN && v));
    case (m_state)
      M_IDLE: if (st) begin m_state = M_RUN; model_clear(); end
      M_RUN: if (v) begin
        for (int j = 0; j < int'(NO); j++) exp_acc[j] += $countones(c[j] & a);
        m_beats++;
        if (m_beats == int'(LEN)) m_state = M_DONE;
      end
      default: if (rdy) m_state = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Beat payload: 0 all ones, 1 row j active for i<j, 2 activations zero, 3 random.
  task automatic gen(input int pmode, output logic [NO-1:0][NI-1:0] c, output logic [NI-1:0] a);
    c = '1;
    a = '1;
    case (pmode)
      1: for (int j = 0; j < int'(NO); j++)
           for (int i = 0; i < int'(NI); i++) c[j][i] = (i < j);
      2: a = '0;
      3: begin
        for (int j = 0; j < int'(NO); j++)
          for (int i = 0; i < int'(NI); i++) c[j][i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < int'(NI); i++) a[i] = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
  endtask

  // Start a stream and feed beats until the model reaches DONE (bounded).
  // vmode: 0 always valid, 1 alternate starting low, 2 random. sflood: pulse start mid-run.
  task automatic run_stream(input int pmode, input int vmode, input bit sflood, input int exp_cycles);
    logic [NO-1:0][NI-1:0] c;
    logic [NI-1:0]         a;
    int                    guard;
    bit                    v;
    gen(pmode, c, a);
    cyc(1'b1, 1'b0, 1'b0, c, a);
    guard = 0;
    while (m_state == M_RUN && guard < 4 * int'(LEN)) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 1);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      gen(pmode, c, a);
      cyc(sflood && (guard % 7 == 3), v, 1'b0, c, a);
      guard++;
    end
    check("stream_done", 64'(m_state == M_DONE), 64'(1));
    if (exp_cycles > 0) check("run_cycles", 64'(guard), 64'(exp_cycles));
  endtask

  task automatic drain();
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    check("idle_after_ready", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [NO-1:0][NI-1:0] ones_c;
    logic [NI-1:0]         ones_a;
    ones_c = '1;
    ones_a = '1;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cmp_out = '0; act_bit = '0;
    m_state = M_IDLE;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check("rng_en_reset", 64'(rng_en), 64'(0));
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, ones_c, ones_a);

    // All-ones stream: every neuron counts DIM_IN*LEN.
    run_stream(0, 0, 1'b0, int'(LEN));
    for (int j = 0; j < int'(NO); j++) check("ones_total", 64'(acc_out[j]), 64'(NI * LEN));
    drain();
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    check("hold_in_idle", 64'(acc_out[0]), 64'(NI * LEN));

    // Alternating stall: twice the RUN cycles, same total.
    run_stream(0, 1, 1'b0, 2 * int'(LEN));
    for (int j = 0; j < int'(NO); j++) check("stall_total", 64'(acc_out[j]), 64'(NI * LEN));
    drain();

    // Row j has j active weights.
    run_stream(1, 0, 1'b0, int'(LEN));
    for (int j = 0; j < int'(NO); j++) check("tri_total", 64'(acc_out[j]), 64'(LEN * j));
    drain();

    // Reset mid-run at beat 100.
    cyc(1'b1, 1'b0, 1'b0, ones_c, ones_a);
    repeat (100) cyc(1'b0, 1'b1, 1'b0, ones_c, ones_a);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    m_state = M_IDLE;
    model_clear();
    check("rst_rng_en", 64'(rng_en), 64'(0));
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, ones_c, ones_a);
    run_stream(0, 0, 1'b0, int'(LEN));
    for (int j = 0; j < int'(NO); j++) check("post_rst_total", 64'(acc_out[j]), 64'(NI * LEN));

    // start during DONE with out_ready low, then start together with out_ready.
    repeat (10) cyc(1'b1, 1'b1, 1'b0, '0, '1);
    check("done_hold", 64'(acc_out[NO-1]), 64'(NI * LEN));
    cyc(1'b1, 1'b0, 1'b1, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);

    // start pulses during RUN are ignored.
    run_stream(0, 0, 1'b1, int'(LEN));
    drain();

    // Zero activations still complete normally.
    run_stream(2, 0, 1'b0, int'(LEN));
    for (int j = 0; j < int'(NO); j++) check("zero_total", 64'(acc_out[j]), 64'(0));
    drain();

    // Random payloads with random stalls.
    for (int k = 0; k < 2; k++) begin
      run_stream(3, 2, 1'b1, 0);
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b1, 1'b0, '1, '1);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_accum.md
SC_ACCUM -- requirements
Module: sc_accum

Interface
REQ-001 Parameter DIM_IN, default 110: input neurons per output, equal to the cmp_weight DIM_IN.
REQ-002 Parameter DIM_OUT, default 8: output neurons handled in parallel, equal to the cmp_weight row count.
REQ-003 Parameter INWD, default 8: bitstream length exponent; stream length LEN = 2^INWD beats.
REQ-004 Derived constant ACCWD = INWD + clog2(DIM_IN+1): accumulator width; not overridable.
REQ-005 clk  in  1: single clock; all state rising-edge.
REQ-006 rst_n  in  1: asynchronous active-low reset.
REQ-007 start  in  1: one-cycle request to begin a new stream; honoured only in IDLE.
REQ-008 in_valid  in  1: cmp_out and act_bit are valid this cycle.
REQ-009 cmp_out  in  DIM_OUT x DIM_IN: weight bitstream bits from cmp_weight.
REQ-010 act_bit  in  DIM_IN: activation bitstream bits, one per input neuron.
REQ-011 rng_en  out  1: advance enable for the upstream RNG counters; high in RUN when in_valid is high.
REQ-012 busy  out  1: high in RUN or DONE.
REQ-013 out_valid  out  1: acc_out is final; high in DONE.
REQ-014 out_ready  in  1: consumer accepts acc_out when out_valid is high.
REQ-015 acc_out  out  DIM_OUT x ACCWD: per-neuron ones count of the product streams, unsigned.

Function
REQ-016 FSM states are IDLE, RUN and DONE; reset state is IDLE.
REQ-017 IDLE to RUN on start=1; accumulators clear to 0 and the beat counter clears to 0 on the same edge.
REQ-018 In RUN with in_valid=1, acc[j] += popcount over i of (cmp_out[j][i] AND act_bit[i]), and the beat counter increments.
REQ-019 In RUN with in_valid=0, the accumulators and the beat counter hold (stall).
REQ-020 Accepting the beat with counter value LEN-1 moves RUN to DONE on that edge; exactly LEN valid beats are accumulated.
REQ-021 Beat counter width is INWD+1; wrap-around never occurs.
REQ-022 In DONE, acc_out is held stable; DONE to IDLE on out_ready=1.
REQ-023 start is ignored in RUN and DONE; start in the same cycle as the DONE-to-IDLE edge is ignored.
REQ-024 in_valid is ignored outside RUN, and rng_en=0 outside RUN.
REQ-025 The accumulator cannot overflow: the maximum is DIM_IN*LEN < 2^ACCWD.
REQ-026 Latency from the last valid beat to out_valid=1 is 1 cycle.
REQ-027 acc_out shows the accumulator registers in every state and retains the last result in IDLE until the next start.

Reset
REQ-028 Asserting rst_n low at any time, including mid-RUN, forces IDLE, acc=0, beat counter=0, out_valid=0, busy=0 and rng_en=0 immediately.
REQ-029 After rst_n deasserts, the block waits in IDLE for start; no partial result is ever flagged valid.

Structure
REQ-030 DIM_IN, DIM_OUT, INWD, ACCWD and the FSM state enum live in the shared package sc_pkg.
REQ-031 A combinational sub-module sc_popcnt (DIM_IN bits in, clog2(DIM_IN+1) bits out) is instantiated once per output neuron.
REQ-032 All registers use a single always_ff with asynchronous active-low reset; the product and popcount logic is combinational.

Verification
REQ-033 Reset, then start, then 256 beats with all cmp_out=1 and act_bit=1 -> out_valid=1 one cycle after the last beat; every acc_out=28160 (110*256).
REQ-034 Same stimulus with in_valid low on alternating cycles -> result 28160 after 512 RUN cycles; rng_en tracks in_valid.
REQ-035 Row j set so that cmp_out[j][i]=1 only for i<j, act_bit all 1, 256 beats -> acc_out[j]=256*j.
REQ-036 Reset pulsed at beat 100 -> IDLE, all outputs 0; a new start with 256 all-ones beats -> 28160.
REQ-037 start asserted during RUN and during DONE, and out_ready held low for 10 cycles -> no restart; acc_out stable; IDLE on the first out_ready.
REQ-038 act_bit=0 with cmp_out=1 for the full stream -> acc_out all 0, out_valid asserted normally.
